// File: rtl/jt12_phase_op_pkg.sv
// Shared widths, slot count and ROM-generation functions for the jt12 phase-to-sample operator.
package jt12_phase_op_pkg;

    localparam int SLOTS         = 24;
    localparam int PHASE_W       = 10;
    localparam int EG_W          = 10;
    localparam int ATTEN_W       = 13;
    localparam int OUT_W         = 14;
    localparam int LOGSIN_W      = 12;
    localparam int EXP_W         = 10;
    localparam int FB_SHIFT_BASE = 10;
    // Clocks between a slot entering stage VIII and its result leaving stage XI.
    localparam int PIPE_LAT      = 3;

    localparam real PI = 3.14159265358979323846;

    // Quarter-wave log-sine: round(-log2(sin((i+0.5)*pi/512)) * 256)
    function automatic logic [LOGSIN_W-1:0] logsin_val(input int idx);
        real x;
        x = ($itor(idx) + 0.5) * PI / 512.0;
        return LOGSIN_W'($rtoi(-$ln($sin(x)) / $ln(2.0) * 256.0 + 0.5));
    endfunction

    // Fractional exponential mantissa: round(2^((255-i)/256) * 1024) - 1024
    function automatic logic [EXP_W-1:0] exp_val(input int idx);
        return EXP_W'($rtoi($pow(2.0, (255.0 - $itor(idx)) / 256.0) * 1024.0 + 0.5) - 1024);
    endfunction

endpackage

// File: rtl/jt12_phase_op_if.sv
// Slot-multiplexed operator bus: stage VIII inputs in, stage XI sample out.
interface jt12_phase_op_if;
    import jt12_phase_op_pkg::*;

    logic                clk_en;
    logic [PHASE_W-1:0]  phase_VIII;
    logic [PHASE_W-1:0]  pm_VIII;
    logic [EG_W-1:0]     eg_atten_VIII;
    logic                fb_en_VIII;
    logic [2:0]          fb_VIII;
    logic                zero;
    logic [OUT_W-1:0]    op_result_XI;

    modport master (
        output clk_en, phase_VIII, pm_VIII, eg_atten_VIII, fb_en_VIII, fb_VIII, zero,
        input  op_result_XI
    );

    modport slave (
        input  clk_en, phase_VIII, pm_VIII, eg_atten_VIII, fb_en_VIII, fb_VIII, zero,
        output op_result_XI
    );
endinterface

// File: rtl/jt12_phase_op_rom.sv
// LOGSIN (stage IX read) and EXP (stage XI read) ROMs with clk_en-gated registered outputs.
module jt12_phase_op_rom
    import jt12_phase_op_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic [7:0]          logsin_addr,
    input  logic [7:0]          exp_addr,
    output logic [LOGSIN_W-1:0] logsin_reg,
    output logic [EXP_W:0]      mant_reg
);
    logic [LOGSIN_W-1:0] logsin_rom [256];
    logic [EXP_W-1:0]    exp_rom    [256];

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_rom
            assign logsin_rom[gi] = logsin_val(gi);
            assign exp_rom[gi]    = exp_val(gi);
        end
    endgenerate

    // The mantissa register holds the implicit leading one, so its cleared state yields a zero sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            logsin_reg <= '0;
            mant_reg   <= '0;
        end else if (clk_en) begin
            logsin_reg <= logsin_rom[logsin_addr];
            mant_reg   <= {1'b1, exp_rom[exp_addr]};
        end
    end
endmodule

// File: rtl/jt12_sh_rst.sv
// Clock-enabled shift register with asynchronous active-high clear; drop is the oldest stage.
module jt12_sh_rst #(
    parameter int width  = 5,
    parameter int stages = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [width-1:0] din,
    output logic [width-1:0] drop
);
    logic [width-1:0] bits_reg [stages];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < stages; i++) bits_reg[i] <= '0;
        end else if (cen) begin
            bits_reg[0] <= din;
            for (int i = 1; i < stages; i++) bits_reg[i] <= bits_reg[i-1];
        end
    end

    assign drop = bits_reg[stages-1];
endmodule

// File: rtl/jt12_phase_op.sv
// Operator stage VIII..XI: phase modulation and feedback, log-sin, attenuation, exp, sign.
// Optional self-feedback history is enabled by defining JT12_PHASE_OP_FB_EN.
module jt12_phase_op
    import jt12_phase_op_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    jt12_phase_op_if.slave bus
);
    logic [PHASE_W-1:0]  fb_term;
    logic                unused_bits;

`ifdef JT12_PHASE_OP_FB_EN
    logic [OUT_W-1:0] prev1;
    logic [OUT_W-1:0] prev2;
    logic [OUT_W:0]   fb_sum;
    logic [OUT_W:0]   fb_shifted;
    logic [3:0]       fb_shift;

    assign fb_sum      = {prev1[OUT_W-1], prev1} + {prev2[OUT_W-1], prev2};
    assign fb_shift    = 4'(FB_SHIFT_BASE) - {1'b0, bus.fb_VIII};
    assign fb_shifted  = $signed(fb_sum) >>> fb_shift;
    assign fb_term     = (bus.fb_en_VIII && bus.fb_VIII != 3'd0) ? fb_shifted[PHASE_W-1:0] : '0;
    assign unused_bits = ^{bus.zero, fb_shifted[OUT_W:PHASE_W]};

    // The output already lags stage VIII by the pipeline depth, so the first history
    // is that much shorter; both drops then belong to the slot now in stage VIII.
    jt12_sh_rst #(.width(OUT_W), .stages(SLOTS - PIPE_LAT)) u_prev1 (
        .clk  (clk),
        .rst  (~rst_n),
        .cen  (bus.clk_en),
        .din  (bus.op_result_XI),
        .drop (prev1)
    );

    jt12_sh_rst #(.width(OUT_W), .stages(SLOTS)) u_prev2 (
        .clk  (clk),
        .rst  (~rst_n),
        .cen  (bus.clk_en),
        .din  (prev1),
        .drop (prev2)
    );
`else
    assign fb_term     = '0;
    assign unused_bits = ^{bus.zero, bus.fb_en_VIII, bus.fb_VIII};
`endif

    logic [PHASE_W-1:0]  phase_sum_next;
    logic [PHASE_W-1:0]  phase_sum_reg;
    logic [EG_W-1:0]     eg_ix_reg;
    logic [EG_W-1:0]     eg_x_reg;
    logic                sign_x_reg;
    logic                sign_xi_reg;
    logic [4:0]          shift_xi_reg;
    logic [7:0]          logsin_addr;
    logic [7:0]          exp_addr;
    logic [LOGSIN_W-1:0] logsin_x;
    logic [EXP_W:0]      mant_xi;
    logic [ATTEN_W:0]    atten_wide;
    logic [ATTEN_W-1:0]  atten;
    logic [ATTEN_W-1:0]  mag;

    assign phase_sum_next = bus.phase_VIII + bus.pm_VIII + fb_term;

    // Upper half of each half-wave reads the quarter-wave table backwards.
    assign logsin_addr = phase_sum_reg[8] ? ~phase_sum_reg[7:0] : phase_sum_reg[7:0];

    assign atten_wide = {2'b00, logsin_x} + {2'b00, eg_x_reg, 2'b00};
    assign atten      = atten_wide[ATTEN_W] ? '1 : atten_wide[ATTEN_W-1:0];
    assign exp_addr   = atten[7:0];

    jt12_phase_op_rom u_rom (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (bus.clk_en),
        .logsin_addr (logsin_addr),
        .exp_addr    (exp_addr),
        .logsin_reg  (logsin_x),
        .mant_reg    (mant_xi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_sum_reg <= '0;
            eg_ix_reg     <= '0;
            eg_x_reg      <= '0;
            sign_x_reg    <= 1'b0;
            sign_xi_reg   <= 1'b0;
            shift_xi_reg  <= '0;
        end else if (bus.clk_en) begin
            phase_sum_reg <= phase_sum_next;
            eg_ix_reg     <= bus.eg_atten_VIII;
            sign_x_reg    <= phase_sum_reg[9];
            eg_x_reg      <= eg_ix_reg;
            sign_xi_reg   <= sign_x_reg;
            shift_xi_reg  <= atten[ATTEN_W-1:8];
        end
    end

    // Shifts of 13 or more empty the 13-bit magnitude entirely.
    assign mag = {mant_xi, 2'b00} >> shift_xi_reg;
    assign bus.op_result_XI = sign_xi_reg ? ~{1'b0, mag} : {1'b0, mag};
endmodule

// File: tb/tb_jt12_phase_op.sv
// Directed-vector bench for jt12_phase_op: streamed table, clk_en gating, reset, feedback frames.
module tb_jt12_phase_op;

    localparam real M_PI = 3.141592653589793;

    typedef struct {
        logic [9:0]  phase;
        logic [9:0]  pm;
        logic [9:0]  eg;
        logic        fb_en;
        logic [2:0]  fb;
        logic [13:0] expected;
    } tv_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    tv_t  vecs[$];
    tv_t  idle;

    jt12_phase_op_if bus();

    jt12_phase_op dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sample from a phase_sum and envelope value, in plain real arithmetic.
    function automatic logic [13:0] op_ref(input logic [9:0] ps, input logic [9:0] eg);
        int  idx, att, mant, mag;
        real x;
        idx  = ps[8] ? 255 - int'(ps[7:0]) : int'(ps[7:0]);
        x    = ($itor(idx) + 0.5) * M_PI / 512.0;
        att  = $rtoi(-$ln($sin(x)) / $ln(2.0) * 256.0 + 0.5) + 4 * int'(eg);
        if (att > 8191) att = 8191;
        mant = $rtoi($pow(2.0, $itor(255 - att % 256) / 256.0) * 1024.0 + 0.5);
        mag  = (att / 256 >= 13) ? 0 : (mant * 4) >> (att / 256);
        return ps[9] ? 14'(16383 - mag) : 14'(mag);
    endfunction

    function automatic int s14(input logic [13:0] v);
        return v[13] ? int'(v) - 16384 : int'(v);
    endfunction

    function automatic tv_t mk(input logic [9:0] phase, input logic [9:0] pm, input logic [9:0] eg,
                               input logic fb_en, input logic [2:0] fb, input logic [13:0] expected);
        tv_t v;
        v.phase = phase; v.pm = pm; v.eg = eg; v.fb_en = fb_en; v.fb = fb; v.expected = expected;
        return v;
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
        end else begin
            $display("ok   %s: 0x%04h", name, act);
        end
    endtask

    task automatic drive(input tv_t v, input logic z);
        bus.phase_VIII    = v.phase;
        bus.pm_VIII       = v.pm;
        bus.eg_atten_VIII = v.eg;
        bus.fb_en_VIII    = v.fb_en;
        bus.fb_VIII       = v.fb;
        bus.zero          = z;
    endtask

    // One slot per clock; result of slot i is sampled after the third following edge.
    task automatic run_stream(input int gate_at, input string tag);
        int n;
        n = vecs.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i == gate_at) begin
                bus.clk_en        = 1'b0;
                bus.phase_VIII    = 10'h155;
                bus.eg_atten_VIII = 10'h000;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    check($sformatf("%s_hold%0d", tag, k), bus.op_result_XI, vecs[i-3].expected);
                end
                bus.clk_en = 1'b1;
            end
            drive((i < n) ? vecs[i] : idle, (i % 24) == 0);
            @(posedge clk); #1;
            if (i >= 2) check($sformatf("%s_%0d", tag, i - 2), bus.op_result_XI, vecs[i-2].expected);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [13:0] r0, r1, r2;
        logic [9:0]  ps1, ps2;
        int          fbv;

        checks = 0;
        errors = 0;
        idle   = mk(10'h000, 10'h000, 10'h3FF, 1'b0, 3'd0, 14'h0000);
        rst_n  = 1'b0;
        bus.clk_en = 1'b0;
        drive(mk(10'h100, 10'h000, 10'h000, 1'b0, 3'd0, 14'h0), 1'b0);

        vecs.push_back(mk(10'h100, 10'h000, 10'h000, 1'b0, 3'd0, 14'h1FE8));
        vecs.push_back(mk(10'h300, 10'h000, 10'h000, 1'b0, 3'd0, 14'h2017));
        vecs.push_back(mk(10'h0FF, 10'h000, 10'h000, 1'b0, 3'd0, 14'h1FE8));
        vecs.push_back(mk(10'h100, 10'h000, 10'h3FF, 1'b0, 3'd0, 14'h0000));
        vecs.push_back(mk(10'h300, 10'h000, 10'h3FF, 1'b0, 3'd0, 14'h3FFF));
        vecs.push_back(mk(10'h100, 10'h000, 10'h020, 1'b0, 3'd0, 14'h1690));
        vecs.push_back(mk(10'h3F0, 10'h020, 10'h000, 1'b0, 3'd0, op_ref(10'h010, 10'h000)));
        vecs.push_back(mk(10'h200, 10'h000, 10'h000, 1'b0, 3'd0, op_ref(10'h200, 10'h000)));
        vecs.push_back(mk(10'h000, 10'h000, 10'h010, 1'b0, 3'd0, op_ref(10'h000, 10'h010)));
        vecs.push_back(mk(10'h080, 10'h005, 10'h005, 1'b0, 3'd0, op_ref(10'h085, 10'h005)));
        vecs.push_back(mk(10'h2FF, 10'h001, 10'h000, 1'b0, 3'd0, 14'h2017));
        vecs.push_back(mk(10'h1FF, 10'h000, 10'h000, 1'b0, 3'd0, op_ref(10'h000, 10'h000)));
        // fb fields must be ignored on a slot without fb_en
        vecs.push_back(mk(10'h140, 10'h000, 10'h040, 1'b0, 3'd7, op_ref(10'h140, 10'h040)));

        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            bus.clk_en = ~bus.clk_en;
            check("reset_hold", bus.op_result_XI, 14'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.clk_en = 1'b1;

        run_stream(-1, "vec");
        run_stream(6, "gated");

        // Asynchronous reset with slots in flight
        drive(vecs[0], 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("async_reset", bus.op_result_XI, 14'h0000);
        @(posedge clk); #1;
        check("reset_held", bus.op_result_XI, 14'h0000);
        drive(idle, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("flushed_ix", bus.op_result_XI, op_ref(10'h000, 10'h000));
        @(posedge clk); #1;
        check("flushed_new", bus.op_result_XI, 14'h0000);

        // Feedback frames: slot 0 is a fb=7 operator, history starts cleared
        r0 = op_ref(10'h080, 10'h000);
`ifdef JT12_PHASE_OP_FB_EN
        fbv = s14(r0) >>> 3;
        ps1 = 10'((128 + fbv) & 1023);
        r1  = op_ref(ps1, 10'h000);
        fbv = (s14(r1) + s14(r0)) >>> 3;
        ps2 = 10'((128 + fbv) & 1023);
        r2  = op_ref(ps2, 10'h000);
`else
        fbv = 0;
        ps1 = 10'h080;
        ps2 = 10'h080;
        r1  = r0;
        r2  = r0;
`endif
        vecs.delete();
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 24; s++) begin
                if (s == 0)
                    vecs.push_back(mk(10'h080, 10'h000, 10'h000, 1'b1, 3'd7,
                                      (f == 0) ? r0 : (f == 1) ? r1 : r2));
                else
                    vecs.push_back(mk(10'h080, 10'h000, 10'h000, 1'b0, 3'd0, r0));
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(-1, "fb");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
